// File: rtl/jtag_tap_datapath.sv
// jtag_tap_datapath: JTAG IR/DR datapath (IDCODE, BYPASS, USER) driven by the TAP state
module jtag_tap_datapath #(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            tck,
    input  logic            trst,
    input  logic [3:0]      state,
    input  logic            tdi,
    input  logic [DR_W-1:0] user_in,
    output logic            tdo,
    output logic            tdo_en,
    output logic [IR_W-1:0] ir,
    output logic [DR_W-1:0] user_out,
    output logic            user_update
);
    localparam logic [3:0] TLR      = 4'd0;
    localparam logic [3:0] CAP_DR   = 4'd3;
    localparam logic [3:0] SHIFT_DR = 4'd4;
    localparam logic [3:0] UPD_DR   = 4'd8;
    localparam logic [3:0] CAP_IR   = 4'd10;
    localparam logic [3:0] SHIFT_IR = 4'd11;
    localparam logic [3:0] UPD_IR   = 4'd15;

    logic [IR_W-1:0] ir_sr;
    logic [31:0]     id_sr;
    logic            byp_sr;
    logic [DR_W-1:0] usr_sr;
    logic            sel_id;
    logic            sel_usr;
    logic            dr_bit;

    assign sel_id  = ir == IR_W'(1);
    assign sel_usr = ir == IR_W'(2);

    // tdo mux: IR or selected DR LSB while shifting, else 0
    always_comb begin
        dr_bit = sel_id ? id_sr[0] : sel_usr ? usr_sr[0] : byp_sr;
        tdo_en = (state == SHIFT_DR) || (state == SHIFT_IR);
        tdo    = (state == SHIFT_IR) ? ir_sr[0] : (state == SHIFT_DR) ? dr_bit : 1'b0;
    end

    // capture/shift/update of IR and DRs; unselected registers hold
    always_ff @(posedge tck) begin
        if (trst) begin
            ir          <= IR_W'(1);
            ir_sr       <= '0;
            id_sr       <= '0;
            byp_sr      <= 1'b0;
            usr_sr      <= '0;
            user_out    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            case (state)
                TLR:      ir <= IR_W'(1);
                CAP_IR:   ir_sr <= IR_W'(1);
                SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                UPD_IR:   ir <= ir_sr;
                CAP_DR: begin
                    if (sel_id) id_sr <= IDCODE_VAL;
                    else if (sel_usr) usr_sr <= user_in;
                    else byp_sr <= 1'b0;
                end
                SHIFT_DR: begin
                    if (sel_id) id_sr <= {tdi, id_sr[31:1]};
                    else if (sel_usr) usr_sr <= DR_W'({tdi, usr_sr} >> 1);
                    else byp_sr <= tdi;
                end
                UPD_DR: begin
                    if (sel_usr) begin
                        user_out    <= usr_sr;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_datapath.sv
// tb_jtag_tap_datapath: directed self-checking bench for jtag_tap_datapath
module tb_jtag_tap_datapath;
    localparam logic [3:0] TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SHIFT_DR = 4, EXIT1_DR = 5,
                           UPD_DR = 8, SEL_IR = 9, CAP_IR = 10, SHIFT_IR = 11, EXIT1_IR = 12,
                           PAUSE_IR = 13, EXIT2_IR = 14, UPD_IR = 15;

    logic       tck = 1'b0;
    logic       trst;
    logic [3:0] state;
    logic       tdi;
    logic [7:0] user_in;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir;
    logic [7:0] user_out;
    logic       user_update;

    int n_chk = 0;
    int n_err = 0;

    jtag_tap_datapath dut (
        .tck(tck), .trst(trst), .state(state), .tdi(tdi), .user_in(user_in),
        .tdo(tdo), .tdo_en(tdo_en), .ir(ir), .user_out(user_out), .user_update(user_update)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic d);
        state = s;
        tdi   = d;
        #1;
    endtask

    task automatic tick();
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic step(input logic [3:0] s);
        drive(s, 1'b0);
        tick();
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [3:0] out);
        step(SEL_DR);
        step(SEL_IR);
        step(CAP_IR);
        for (int i = 0; i < 4; i++) begin
            drive(SHIFT_IR, v[i]);
            out[i] = tdo;
            tick();
        end
        step(EXIT1_IR);
        step(UPD_IR);
    endtask

    task automatic dr_scan(input logic [31:0] din, input int n, output logic [31:0] dout, output logic en);
        dout = '0;
        en   = 1'b1;
        step(SEL_DR);
        step(CAP_DR);
        for (int i = 0; i < n; i++) begin
            drive(SHIFT_DR, din[i]);
            dout[i] = tdo;
            en      = en & tdo_en;
            tick();
        end
        step(EXIT1_DR);
        step(UPD_DR);
    endtask

    logic [3:0]  iro;
    logic [31:0] dro;
    logic        en;

    initial begin
        trst    = 1'b1;
        user_in = 8'h00;
        @(negedge tck);
        drive(TLR, 1'b0);
        tick();
        tick();
        trst = 1'b0;
        #1;
        check("rst_ir", 32'(ir), 32'h1);
        check("rst_user_out", 32'(user_out), 32'h0);
        check("rst_user_update", 32'(user_update), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_tdo_en", 32'(tdo_en), 32'h0);

        step(TLR);
        step(RTI);
        dr_scan(32'h0, 32, dro, en);
        check("idcode_out", dro, 32'h1000_0001);
        check("idcode_tdo_en", 32'(en), 32'h1);
        check("idcode_ir", 32'(ir), 32'h1);
        check("idcode_no_update", 32'(user_update), 32'h0);
        step(RTI);

        ir_scan(4'hF, iro);
        check("ir_capture_out", 32'(iro), 32'h1);
        check("ir_bypass", 32'(ir), 32'hF);
        dr_scan(32'b01101, 5, dro, en);
        check("bypass_out", dro, 32'b11010);
        check("bypass_no_update", 32'(user_update), 32'h0);
        step(RTI);

        ir_scan(4'h2, iro);
        check("ir_user", 32'(ir), 32'h2);
        user_in = 8'h3C;
        dr_scan(32'hA5, 8, dro, en);
        check("user_capture_out", dro, 32'h3C);
        check("user_update_hi", 32'(user_update), 32'h1);
        check("user_out", 32'(user_out), 32'hA5);
        step(RTI);
        check("user_update_lo", 32'(user_update), 32'h0);

        ir_scan(4'h7, iro);
        check("ir_undef", 32'(ir), 32'h7);
        dr_scan(32'b10110, 5, dro, en);
        check("undef_bypass_out", dro, 32'b01100);
        check("undef_user_out_hold", 32'(user_out), 32'hA5);
        check("undef_no_update", 32'(user_update), 32'h0);
        step(RTI);

        ir_scan(4'h2, iro);
        step(TLR);
        check("tlr_ir", 32'(ir), 32'h1);

        ir_scan(4'h2, iro);
        user_in = 8'hFF;
        step(SEL_DR);
        step(CAP_DR);
        for (int i = 0; i < 3; i++) step(SHIFT_DR);
        trst = 1'b1;
        drive(SHIFT_DR, 1'b1);
        tick();
        trst = 1'b0;
        check("trst_ir", 32'(ir), 32'h1);
        check("trst_user_out", 32'(user_out), 32'h0);
        check("trst_user_update", 32'(user_update), 32'h0);
        step(UPD_DR);
        check("trst_no_update", 32'(user_update), 32'h0);
        step(UPD_IR);
        check("trst_ir_sr_clear", 32'(ir), 32'h0);
        step(TLR);
        check("trst_tlr_ir", 32'(ir), 32'h1);

        step(RTI);
        step(SEL_DR);
        step(SEL_IR);
        step(CAP_IR);
        iro = '0;
        for (int i = 0; i < 3; i++) begin
            drive(SHIFT_IR, i == 1);
            iro[i] = tdo;
            tick();
        end
        step(EXIT1_IR);
        drive(PAUSE_IR, 1'b1);
        check("pause_tdo_en", 32'(tdo_en), 32'h0);
        check("pause_tdo", 32'(tdo), 32'h0);
        for (int i = 0; i < 5; i++) step(PAUSE_IR);
        step(EXIT2_IR);
        drive(SHIFT_IR, 1'b0);
        iro[3] = tdo;
        tick();
        step(EXIT1_IR);
        step(UPD_IR);
        check("pause_ir_out", 32'(iro), 32'h1);
        check("pause_ir", 32'(ir), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_tap_datapath.md
# jtag_tap_datapath

Instruction- and data-register datapath for the JTAG test access port. It sits directly downstream of the TAP state machine: it consumes the registered 4-bit TAP state and TDI, and produces TDO. It holds the instruction register (IR) and the IDCODE, BYPASS and one user data register, and captures, shifts and updates each register as the TAP state dictates.

## Interface
- IR_W, 4: instruction register width (>= 2).
- DR_W, 8: user data register width (>= 1).
- IDCODE_VAL, 32'h1000_0001: device ID; bit 0 must be 1.
- tck  input  1  test clock; all logic on its rising edge.
- trst  input  1  reset, synchronous, active-high.
- state  input  4  TAP state from the controller. Encoding: 0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPD_DR, 9 SEL_IR, 10 CAP_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPD_IR.
- tdi  input  1  serial test data in.
- user_in  input  DR_W  parallel value captured into the user DR.
- tdo  output  1  serial test data out; 0 when tdo_en=0.
- tdo_en  output  1  high while state is SHIFT_DR or SHIFT_IR.
- ir  output  IR_W  active instruction.
- user_out  output  DR_W  user DR update register.
- user_update  output  1  one-cycle pulse on each user DR update.

## Operation
- Instructions: IDCODE = 1; USER = 2; BYPASS = all ones. Any other code selects BYPASS.
- Registers:
  - ir_sr: IR_W-bit IR shift register.
  - id_sr: 32-bit IDCODE shift register.
  - byp_sr: 1-bit BYPASS register.
  - usr_sr: DR_W-bit user shift register.
  - ir: the active instruction.
  - user_out: the user update register.
- Each action below happens on the rising tck edge while state has the value named.
- CAP_IR: ir_sr <= {0..0, 2'b01}.
- SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]}.
- UPD_IR: ir <= ir_sr.
- TLR: ir <= IDCODE on every cycle. The DR shift registers hold their values.
- CAP_DR: only the register selected by ir loads.
  - id_sr <= IDCODE_VAL.
  - byp_sr <= 0.
  - usr_sr <= user_in.
- SHIFT_DR: the selected register shifts right, tdi in at the MSB. Unselected registers hold.
- UPD_DR, when ir = USER: user_out <= usr_sr, and user_update goes high for exactly the next cycle. With other instructions, UPD_DR has no effect.
- All other states (RTI, SEL_*, EXIT*, PAUSE*): every register holds.
- tdo is combinational:
  - SHIFT_IR: ir_sr[0].
  - SHIFT_DR: bit 0 of the selected DR.
  - Otherwise 0.
- ir changes only in UPD_IR, TLR or reset. The DR selection therefore stays fixed through a whole DR scan.

## Timing
- Reset values (trst high at an edge):
  - ir = IDCODE.
  - ir_sr, id_sr, byp_sr, usr_sr, user_out = 0.
  - user_update = 0.
  - tdo and tdo_en follow state combinationally; with state = TLR both are 0.
- trst takes priority over every state action, including mid-shift. A partial shift is discarded, and user_out is cleared.
- Capture-to-TDO latency:
  - The first captured bit appears on tdo in the cycle state enters SHIFT_*.
  - Each later bit appears one tck after the previous one.
- BYPASS: tdo equals tdi delayed by exactly one SHIFT_DR cycle. The first bit out is 0.
- IR: the first two bits out are 1, then 0. N shift cycles move N bits. PAUSE/EXIT2 and re-entry into SHIFT resume without losing bits.
- user_update:
  - High in the cycle after the UPD_DR edge.
  - Never high for two consecutive cycles unless UPD_DR is held (the FSM cannot do this).

## Test plan
- Reset, then TLR→RTI→SEL_DR→CAP_DR, then 32 SHIFT_DR cycles with default IDCODE_VAL -> tdo emits 32'h1000_0001 LSB first (1,0,0,…,1 at bit 28); ir = 1 throughout.
- CAP_IR then 4 SHIFT_IR cycles with tdi = 1,1,1,1, then EXIT1_IR→UPD_IR -> tdo = 1,0,0,0 and ir = 4'hF. Then a DR scan shifting tdi = 1,0,1,1,0 -> tdo = 0,1,0,1,1.
- Load ir = 2 and capture with user_in = 8'h3C. Shift tdi = 8'hA5 LSB first, then UPD_DR -> tdo = 8'h3C LSB first, user_out = 8'hA5, and user_update high for one cycle.
- Load ir = 4'h7 (undefined), then a DR scan -> behaves as BYPASS (1-cycle delay, leading 0).
- Load ir = 2, then hold state = TLR for one cycle -> ir = 1. Separately, assert trst during the 4th SHIFT_DR bit of a user scan -> all registers return to reset values and user_update stays 0.
- Shift 3 IR bits, then EXIT1_IR→PAUSE_IR (5 cycles)→EXIT2_IR→SHIFT_IR for 1 bit (tdi pattern 0,1,0 then 0), then UPD_IR -> ir = 4'h2; no bit is lost across the pause.
